// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register and write-back stage: drives the register-file write port,
// forwards same-cycle writes to the decode read ports and tracks retired instructions.
module mem_wb_writeback #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5,
  parameter int PC_W   = 8,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              mem_MemtoReg,
  input  logic              mem_regwrite,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic [REG_W-1:0]  mem_rd,
  input  logic [PC_W-1:0]   mem_pc,
  input  logic              stall,
  input  logic              flush,
  output logic              wb_RegWrite,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic [DATA_W-1:0] id_rdata1,
  output logic [DATA_W-1:0] id_rdata2,
  output logic [PC_W-1:0]   retire_pc,
  output logic [CNT_W-1:0]  retire_count
);

  logic                     vld_p1;
  logic                     memtoreg_p1;
  logic                     regwrite_p1;
  logic [REG_W-1:0]         rd_p1;
  logic signed [DATA_W-1:0] alu_p1;
  logic signed [DATA_W-1:0] ld_p1;
  logic [PC_W-1:0]          pc_p1;
  logic                     retire;

  // ---- MEM -> WB stage boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      memtoreg_p1 <= 1'b0;
      regwrite_p1 <= 1'b0;
      rd_p1       <= '0;
      alu_p1      <= '0;
      ld_p1       <= '0;
      pc_p1       <= '0;
    end else begin
      if (flush)
        vld_p1 <= 1'b0;
      else if (!stall)
        vld_p1 <= mem_valid;
      if (!stall) begin
        memtoreg_p1 <= mem_MemtoReg;
        regwrite_p1 <= mem_regwrite;
        rd_p1       <= mem_rd;
        alu_p1      <= mem_alu_result;
        ld_p1       <= mem_read_data;
        pc_p1       <= mem_pc;
      end
    end
  end

  // ---- WB stage: register-file write port and decode bypass ----
  assign wb_data     = memtoreg_p1 ? ld_p1 : alu_p1;
  assign wb_rd       = rd_p1;
  assign wb_RegWrite = vld_p1 & regwrite_p1 & (rd_p1 != '0);

  // x0 is never bypassed because wb_RegWrite is already gated on rd != 0
  assign id_rdata1 = (wb_RegWrite && (wb_rd == id_rs1)) ? wb_data : rf_rdata1;
  assign id_rdata2 = (wb_RegWrite && (wb_rd == id_rs2)) ? wb_data : rf_rdata2;

  // An instruction retires on the edge where it leaves the stage, so a stalled one counts once
  assign retire = vld_p1 & ~stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_pc    <= '0;
      retire_count <= '0;
    end else if (retire) begin
      retire_pc    <= pc_p1;
      retire_count <= retire_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Self-checking bench for mem_wb_writeback: vector table with a scoreboard queue,
// plus hand-written stall/flush, async-reset and counter-wrap sequences.
module tb_mem_wb_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_MemtoReg, mem_regwrite;
  logic [63:0] mem_alu_result, mem_read_data;
  logic [4:0]  mem_rd;
  logic [7:0]  mem_pc;
  logic        stall, flush;
  logic        wb_RegWrite;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic [4:0]  id_rs1, id_rs2;
  logic [63:0] rf_rdata1, rf_rdata2, id_rdata1, id_rdata2;
  logic [7:0]  retire_pc;
  logic [31:0] retire_count;

  mem_wb_writeback dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_MemtoReg(mem_MemtoReg), .mem_regwrite(mem_regwrite),
    .mem_alu_result(mem_alu_result), .mem_read_data(mem_read_data),
    .mem_rd(mem_rd), .mem_pc(mem_pc), .stall(stall), .flush(flush),
    .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
    .retire_pc(retire_pc), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v, m2r, rw;
    logic [4:0]  rd;
    logic [63:0] alu, ld;
    logic [7:0]  pc;
    logic [4:0]  rs1, rs2;
    logic [63:0] rf1, rf2;
    logic        exp_we;
    logic [4:0]  exp_rd;
    logic [63:0] exp_data, exp_id1, exp_id2;
  } vec_t;

  vec_t vecs[7];
  vec_t sb[$];
  vec_t e;

  int total = 0;
  int bad = 0;

  // reference model of the retire bookkeeping
  logic        m_valid = 1'b0;
  logic [7:0]  m_pc = '0;
  logic [31:0] m_count = '0;
  logic [7:0]  m_retpc = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (m_valid && !stall) begin
      m_count = m_count + 32'd1;
      m_retpc = m_pc;
    end
    if (flush) m_valid = 1'b0;
    else if (!stall) m_valid = mem_valid;
    if (!stall) m_pc = mem_pc;
    #1;
  endtask

  task automatic set_instr(input logic v, input logic m2r, input logic rw, input logic [4:0] rd,
                           input logic [63:0] alu, input logic [63:0] ld, input logic [7:0] pc);
    mem_valid = v; mem_MemtoReg = m2r; mem_regwrite = rw; mem_rd = rd;
    mem_alu_result = alu; mem_read_data = ld; mem_pc = pc;
  endtask

  task automatic chk_wb(input string name, input logic we, input logic [4:0] rd, input logic [63:0] data);
    chk({name, "_we"}, 64'(wb_RegWrite), 64'(we));
    chk({name, "_rd"}, 64'(wb_rd), 64'(rd));
    chk({name, "_data"}, wb_data, data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] c0;
    vecs[0] = '{1'b1, 1'b0, 1'b1, 5'd5, 64'hDEAD, 64'h0, 8'h01, 5'd5, 5'd6, 64'h11, 64'h22,
                1'b1, 5'd5, 64'hDEAD, 64'hDEAD, 64'h22};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 5'd5, 64'h0, 64'h1234, 8'h02, 5'd4, 5'd5, 64'h33, 64'h44,
                1'b1, 5'd5, 64'h1234, 64'h33, 64'h1234};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 5'd0, 64'h55, 64'h0, 8'h03, 5'd0, 5'd0, 64'h7, 64'h8,
                1'b0, 5'd0, 64'h55, 64'h7, 64'h8};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 5'd7, 64'h77, 64'h0, 8'h04, 5'd7, 5'd7, 64'h1, 64'h2,
                1'b0, 5'd7, 64'h77, 64'h1, 64'h2};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 5'd9, 64'h900, 64'h0, 8'h05, 5'd9, 5'd1, 64'h3, 64'h4,
                1'b0, 5'd9, 64'h900, 64'h3, 64'h4};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 5'd31, 64'h5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h06, 5'd31, 5'd30, 64'h0, 64'h6,
                1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h6};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 5'd3, 64'h99, 64'hBAD, 8'h07, 5'd3, 5'd3, 64'h1, 64'h1,
                1'b1, 5'd3, 64'h99, 64'h99, 64'h99};

    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_instr(1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 64'h0, 8'h0);
    id_rs1 = '0; id_rs2 = '0; rf_rdata1 = '0; rf_rdata2 = '0;
    #1;
    chk_wb("reset", 1'b0, 5'd0, 64'h0);
    chk("reset_count", 64'(retire_count), 64'h0);
    chk("reset_retpc", 64'(retire_pc), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // table-driven vectors through the scoreboard
    for (int i = 0; i < 7; i++) begin
      set_instr(vecs[i].v, vecs[i].m2r, vecs[i].rw, vecs[i].rd, vecs[i].alu, vecs[i].ld, vecs[i].pc);
      sb.push_back(vecs[i]);
      tick();
      id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
      rf_rdata1 = vecs[i].rf1; rf_rdata2 = vecs[i].rf2;
      #1;
      if (sb.size() == 0) begin
        chk("sb_empty", 64'd0, 64'd1);
      end else begin
        e = sb.pop_front();
        chk_wb($sformatf("vec%0d", i), e.exp_we, e.exp_rd, e.exp_data);
        chk($sformatf("vec%0d_id1", i), id_rdata1, e.exp_id1);
        chk($sformatf("vec%0d_id2", i), id_rdata2, e.exp_id2);
        chk($sformatf("vec%0d_count", i), 64'(retire_count), 64'(m_count));
      end
    end
    id_rs2 = 5'd4; rf_rdata2 = 64'h1; #1;
    chk("bypass_miss_id2", id_rdata2, 64'h1);
    chk("bypass_hit_id1", id_rdata1, 64'h99);

    // stall for three cycles on a valid instruction, then release, then flush
    set_instr(1'b1, 1'b0, 1'b1, 5'd6, 64'hAB, 64'h0, 8'h10);
    tick();
    chk_wb("stall_load", 1'b1, 5'd6, 64'hAB);
    c0 = m_count;
    chk("stall_load_count", 64'(retire_count), 64'(c0));
    set_instr(1'b1, 1'b0, 1'b1, 5'd8, 64'hCC, 64'h0, 8'h20);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_wb($sformatf("stall%0d", k), 1'b1, 5'd6, 64'hAB);
      chk($sformatf("stall%0d_count", k), 64'(retire_count), 64'(c0));
    end
    stall = 1'b0;
    tick();
    chk("release_count", 64'(retire_count), 64'(c0 + 32'd1));
    chk("release_retpc", 64'(retire_pc), 64'h10);
    chk_wb("release", 1'b1, 5'd8, 64'hCC);
    flush = 1'b1;
    set_instr(1'b1, 1'b0, 1'b1, 5'd9, 64'hEE, 64'h0, 8'h30);
    tick();
    chk("flush_we", 64'(wb_RegWrite), 64'h0);
    chk("flush_count", 64'(retire_count), 64'(c0 + 32'd2));
    chk("flush_retpc", 64'(retire_pc), 64'h20);
    flush = 1'b0; mem_valid = 1'b0;
    tick();
    chk("bubble_count", 64'(retire_count), 64'(c0 + 32'd2));

    // stall and flush together discard the held instruction uncounted
    set_instr(1'b1, 1'b0, 1'b1, 5'd10, 64'hDD, 64'h0, 8'h40);
    tick();
    chk_wb("sf_load", 1'b1, 5'd10, 64'hDD);
    mem_valid = 1'b0; stall = 1'b1; flush = 1'b1;
    tick();
    chk("sf_we", 64'(wb_RegWrite), 64'h0);
    chk("sf_count", 64'(retire_count), 64'(c0 + 32'd2));
    stall = 1'b0; flush = 1'b0;
    tick();
    chk("sf_after_count", 64'(retire_count), 64'(c0 + 32'd2));
    chk("sf_after_retpc", 64'(retire_pc), 64'h20);
    chk("model_count", 64'(retire_count), 64'(m_count));

    // asynchronous reset in the middle of a cycle with a valid instruction held
    set_instr(1'b1, 1'b0, 1'b1, 5'd11, 64'hEE, 64'h0, 8'h50);
    tick();
    chk_wb("pre_rst", 1'b1, 5'd11, 64'hEE);
    id_rs1 = 5'd11; rf_rdata1 = 64'h5;
    #2 rst = 1'b1;
    #1;
    chk_wb("async_rst", 1'b0, 5'd0, 64'h0);
    chk("async_rst_count", 64'(retire_count), 64'h0);
    chk("async_rst_retpc", 64'(retire_pc), 64'h0);
    chk("async_rst_id1", id_rdata1, 64'h5);
    m_valid = 1'b0; m_pc = '0; m_count = '0; m_retpc = '0;
    mem_valid = 1'b0;
    #1 rst = 1'b0;
    tick();
    chk("post_rst_count", 64'(retire_count), 64'h0);

    // counter wrap from all-ones to zero
    force dut.retire_count = 32'hFFFF_FFFF;
    m_count = 32'hFFFF_FFFF;
    set_instr(1'b1, 1'b0, 1'b1, 5'd12, 64'h1, 64'h0, 8'h60);
    @(negedge clk);
    release dut.retire_count;
    tick();
    chk("wrap_pre", 64'(retire_count), 64'hFFFF_FFFF);
    mem_valid = 1'b0;
    tick();
    chk("wrap_zero", 64'(retire_count), 64'h0);
    chk("wrap_retpc", 64'(retire_pc), 64'h60);
    chk("wrap_model", 64'(retire_count), 64'(m_count));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
